// File: rtl/irq_pending_sequencer.sv
// Latches 8 interrupt lines into a masked pending vector for an external priority encoder and
// converts the encoder result into a registered req/ack handshake; edge sources clear on ack.
module irq_pending_sequencer #(
  parameter logic [7:0] EDGE_SEL = 8'hFF,
  parameter logic [7:0] MASK_RST = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] irq_in,
  input  logic       mask_we,
  input  logic [7:0] mask_wdata,
  output logic [7:0] pend_out,
  input  logic [2:0] enc_idx,
  input  logic       enc_valid,
  output logic       req,
  output logic [2:0] req_id,
  input  logic       ack,
  output logic [7:0] mask_q
);

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] irq_q;
  logic [7:0] pend_q, pend_d;
  logic [7:0] mask_d;
  logic       req_q, req_d;
  logic [2:0] req_id_q, req_id_d;
  logic [7:0] clr_vec;

  assign clr_vec = (state_q == REQ && ack) ? (8'b1 << req_id_q) : 8'b0;

  // A fresh edge is OR-ed in after the clear, so a same-cycle edge on the serviced bit survives.
  always_comb begin
    pend_d = pend_q;
    for (int i = 0; i < 8; i++) begin
      if (EDGE_SEL[i]) begin
        pend_d[i] = (pend_q[i] & ~clr_vec[i]) | (irq_in[i] & ~irq_q[i]);
      end else begin
        pend_d[i] = irq_in[i];
      end
    end
  end

  assign mask_d = mask_we ? mask_wdata : mask_q;

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    req_id_d = req_id_q;
    case (state_q)
      IDLE: begin
        if (enc_valid) begin
          state_d  = REQ;
          req_d    = 1'b1;
          req_id_d = enc_idx;
        end
      end
      REQ: begin
        if (ack) begin
          state_d = IDLE;
          req_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      irq_q    <= 8'h00;
      pend_q   <= 8'h00;
      mask_q   <= MASK_RST;
      req_q    <= 1'b0;
      req_id_q <= 3'd0;
    end else begin
      state_q  <= state_d;
      irq_q    <= irq_in;
      pend_q   <= pend_d;
      mask_q   <= mask_d;
      req_q    <= req_d;
      req_id_q <= req_id_d;
    end
  end

  assign pend_out = pend_q & mask_q;
  assign req      = req_q;
  assign req_id   = req_id_q;

endmodule

// File: tb/tb_irq_pending_sequencer.sv
// Bench for irq_pending_sequencer: edge-type instance plus a level-type instance, each fed by a
// behavioural 8-to-3 priority encoder; expected request ids go through per-instance queues.
`timescale 1ns/1ps
module tb_irq_pending_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] irq_in, mask_wdata, pend_out, mask_q;
  logic       mask_we, enc_valid, req, ack;
  logic [2:0] enc_idx, req_id;

  logic [7:0] l_irq, l_wdata, l_pend, l_mask;
  logic       l_we, l_valid, l_req, l_ack;
  logic [2:0] l_idx, l_id;

  int n_vec = 0;
  int n_err = 0;
  logic [2:0] exp_q[$];
  logic [2:0] lexp_q[$];
  logic req_prev = 1'b0;
  logic lreq_prev = 1'b0;

  always #5 clk = ~clk;

  irq_pending_sequencer #(.EDGE_SEL(8'hFF), .MASK_RST(8'h00)) u_dut (
    .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .mask_we(mask_we), .mask_wdata(mask_wdata),
    .pend_out(pend_out), .enc_idx(enc_idx), .enc_valid(enc_valid), .req(req), .req_id(req_id),
    .ack(ack), .mask_q(mask_q));

  irq_pending_sequencer #(.EDGE_SEL(8'h00), .MASK_RST(8'h00)) u_lvl (
    .clk(clk), .rst_n(rst_n), .irq_in(l_irq), .mask_we(l_we), .mask_wdata(l_wdata),
    .pend_out(l_pend), .enc_idx(l_idx), .enc_valid(l_valid), .req(l_req), .req_id(l_id),
    .ack(l_ack), .mask_q(l_mask));

  function automatic logic [2:0] prio(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) if (v[i]) r = 3'(i);
    return r;
  endfunction

  always_comb begin
    enc_valid = |pend_out;
    enc_idx   = prio(pend_out);
    l_valid   = |l_pend;
    l_idx     = prio(l_pend);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitors: every new request is compared against the head of its queue.
  always @(negedge clk) begin
    if (rst_n && req && !req_prev) begin
      if (exp_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_req: got req_id %0d, expected no request", req_id);
      end else chk("req_id", 32'(req_id), 32'(exp_q.pop_front()));
    end
    req_prev = req;
  end

  always @(negedge clk) begin
    if (rst_n && l_req && !lreq_prev) begin
      if (lexp_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_lvl_req: got req_id %0d, expected no request", l_id);
      end else chk("lvl_req_id", 32'(l_id), 32'(lexp_q.pop_front()));
    end
    lreq_prev = l_req;
  end

  task automatic wait_req(input bit lvl, input string name);
    int k;
    k = 0;
    while (!(lvl ? l_req : req) && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) begin
      n_vec++; n_err++;
      $display("FAIL %s_timeout: got req=0 after 50 cycles, expected req=1", name);
    end
  endtask

  task automatic do_ack(input bit lvl, input string name);
    wait_req(lvl, name);
    if (lvl) l_ack = 1'b1; else ack = 1'b1;
    @(negedge clk);
    l_ack = 1'b0; ack = 1'b0;
  endtask

  task automatic pulse(input logic [7:0] v);
    irq_in = v;
    @(negedge clk);
    irq_in = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; irq_in = 0; mask_we = 0; mask_wdata = 0; ack = 0;
    l_irq = 0; l_we = 0; l_wdata = 0; l_ack = 0;
    idle(2);
    chk("rst_req", 32'(req), 0);
    chk("rst_req_id", 32'(req_id), 0);
    chk("rst_pend_out", 32'(pend_out), 0);
    chk("rst_mask", 32'(mask_q), 32'h00);
    rst_n = 1'b1;
    idle(1);

    // 1: single edge, latency and clear on ack
    mask_we = 1; mask_wdata = 8'hFF; l_we = 1; l_wdata = 8'hFF;
    @(negedge clk);
    mask_we = 0; l_we = 0;
    chk("mask_readback", 32'(mask_q), 32'hFF);
    exp_q.push_back(3'd2);
    irq_in = 8'h04;
    @(negedge clk);
    irq_in = 8'h00;
    chk("t1_pend_out", 32'(pend_out), 32'h04);
    chk("t1_req_early", 32'(req), 0);
    @(negedge clk);
    chk("t1_req_lat2", 32'(req), 1);
    ack = 1;
    @(negedge clk);
    ack = 0;
    chk("t1_pend_clr", 32'(pend_out), 32'h00);
    chk("t1_req_drop", 32'(req), 0);
    idle(3);

    // 2: simultaneous edges serviced high index first
    exp_q.push_back(3'd7); exp_q.push_back(3'd5); exp_q.push_back(3'd1);
    pulse(8'hA2);
    chk("t2_pend_out", 32'(pend_out), 32'hA2);
    do_ack(0, "t2a");
    chk("t2_gap", 32'(req), 0);
    do_ack(0, "t2b");
    do_ack(0, "t2c");
    idle(3);
    chk("t2_pend_empty", 32'(pend_out), 32'h00);

    // 3: masked source records pending, requests once unmasked
    mask_we = 1; mask_wdata = 8'h00;
    @(negedge clk);
    mask_we = 0;
    pulse(8'h10);
    idle(3);
    chk("t3_pend_masked", 32'(pend_out), 32'h00);
    chk("t3_no_req", 32'(req), 0);
    exp_q.push_back(3'd4);
    mask_we = 1; mask_wdata = 8'h10;
    @(negedge clk);
    mask_we = 0;
    chk("t3_pend_unmasked", 32'(pend_out), 32'h10);
    @(negedge clk);
    chk("t3_req", 32'(req), 1);
    do_ack(0, "t3");
    mask_we = 1; mask_wdata = 8'hFF;
    @(negedge clk);
    mask_we = 0;
    idle(2);

    // 4: new edge on the serviced bit in the ack cycle wins
    exp_q.push_back(3'd6); exp_q.push_back(3'd6);
    pulse(8'h40);
    wait_req(0, "t4a");
    irq_in = 8'h40; ack = 1;
    @(negedge clk);
    irq_in = 8'h00; ack = 0;
    chk("t4_gap", 32'(req), 0);
    chk("t4_pend_kept", 32'(pend_out), 32'h40);
    do_ack(0, "t4b");
    idle(2);
    chk("t4_pend_clr", 32'(pend_out), 32'h00);

    // 5: level source re-requests while held, request survives deassertion
    lexp_q.push_back(3'd3); lexp_q.push_back(3'd3);
    l_irq = 8'h08;
    do_ack(1, "t5a");
    chk("t5_gap", 32'(l_req), 0);
    wait_req(1, "t5b");
    l_irq = 8'h00;
    idle(2);
    chk("t5_req_held", 32'(l_req), 1);
    chk("t5_pend_low", 32'(l_pend), 32'h00);
    do_ack(1, "t5c");
    idle(3);
    chk("t5_req_idle", 32'(l_req), 0);

    // 6: asynchronous reset mid-handshake
    exp_q.push_back(3'd0);
    pulse(8'h01);
    wait_req(0, "t6");
    #2 rst_n = 1'b0;
    #1;
    chk("t6_req_async", 32'(req), 0);
    chk("t6_pend_async", 32'(pend_out), 32'h00);
    chk("t6_mask_async", 32'(mask_q), 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);
    chk("t6_no_req", 32'(req), 0);

    chk("queue_drained", 32'(exp_q.size()), 0);
    chk("lvl_queue_drained", 32'(lexp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
